// File: rtl/sl_receiver_if.sv
// rtl/sl_receiver_if.sv - host-side register and status bundle of the SL receiver
interface sl_receiver_if;
    logic [9:0]  wr_config_w;
    logic        wr_config_enable;
    logic [9:0]  r_config_w;
    logic [31:0] rx_data;
    logic        word_ready;
    logic        read_ack;
    logic        parity_err;
    logic        frame_err;
    logic        overrun;
    logic        rx_busy;
    logic        status_changed;

    // Host side: writes configuration, acknowledges words, observes status
    modport master (
        output wr_config_w, wr_config_enable, read_ack,
        input  r_config_w, rx_data, word_ready, parity_err, frame_err,
        input  overrun, rx_busy, status_changed
    );

    // Receiver side
    modport slave (
        input  wr_config_w, wr_config_enable, read_ack,
        output r_config_w, rx_data, word_ready, parity_err, frame_err,
        output overrun, rx_busy, status_changed
    );
endinterface

// File: rtl/sl_receiver.sv
// rtl/sl_receiver.sv - SL two-wire link receiver with glitch filter, parity and framing checks
module sl_receiver #(
    parameter int SYNC_STAGES  = 2,
    parameter int TIMEOUT_MULT = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         SL0,
    input  logic         SL1,
    sl_receiver_if.slave bus
);
    localparam logic [1:0] SYM_STOP = 2'b00;
    localparam logic [1:0] SYM_ZERO = 2'b01;
    localparam logic [1:0] SYM_ONE  = 2'b10;
    localparam logic [1:0] SYM_SEP  = 2'b11;
    localparam int         TMO_K    = TIMEOUT_MULT * 4;

    typedef enum logic [2:0] {IDLE, DATA, GAP, PAR, PGAP, STOPW, ERR} state_t;

    state_t                 state;
    logic [9:0]             cfg;
    logic [5:0]             bq_eff;
    logic                   irqm;
    logic [5:0]             p_len;
    logic [4:0]             f_len;
    logic [9:0]             tmo_lim;
    logic [SYNC_STAGES-1:0] s0_sr, s1_sr;
    logic [1:0]             sync_sym, cand, filt;
    logic [4:0]             stab_cnt;
    logic                   sym_evt;
    logic [31:0]            data;
    logic [5:0]             bit_cnt;
    logic                   par_bit;
    logic [9:0]             timer;
    logic                   is_bit, frame_hit, word_done, parity_ok;

    // Decode configuration fields into effective bit count, phase length and timeout
    always_comb begin
        bq_eff = (cfg[5:0] == 6'd0 || cfg[5:0] > 6'd32) ? 6'd32 : cfg[5:0];
        irqm   = cfg[6];
        case (cfg[9:7])
            3'd0:    p_len = 6'd2;
            3'd1:    p_len = 6'd4;
            3'd2:    p_len = 6'd8;
            3'd3:    p_len = 6'd16;
            3'd4:    p_len = 6'd32;
            default: p_len = 6'd2;
        endcase
        f_len   = p_len[5:1];
        tmo_lim = 10'(TMO_K) * {4'b0, p_len};
    end

    assign sync_sym       = {s0_sr[SYNC_STAGES-1], s1_sr[SYNC_STAGES-1]};
    assign bus.r_config_w = cfg;
    assign bus.rx_busy    = (state != IDLE);

    // Synchronize both lines and commit a symbol only after it is stable for F clocks
    always_ff @(posedge clk) begin
        if (rst) begin
            s0_sr    <= '1;
            s1_sr    <= '1;
            cand     <= SYM_SEP;
            filt     <= SYM_SEP;
            stab_cnt <= 5'd0;
            sym_evt  <= 1'b0;
        end else begin
            s0_sr   <= {s0_sr[SYNC_STAGES-2:0], SL0};
            s1_sr   <= {s1_sr[SYNC_STAGES-2:0], SL1};
            sym_evt <= 1'b0;
            if (sync_sym != cand) begin
                cand     <= sync_sym;
                stab_cnt <= 5'd1;
                if (f_len == 5'd1 && sync_sym != filt) begin
                    filt    <= sync_sym;
                    sym_evt <= 1'b1;
                end
            end else begin
                if (stab_cnt < f_len)
                    stab_cnt <= stab_cnt + 5'd1;
                if (stab_cnt == f_len - 5'd1 && cand != filt) begin
                    filt    <= cand;
                    sym_evt <= 1'b1;
                end
            end
        end
    end

    // Classify the current filtered change as a framing fault or a completed word
    always_comb begin
        is_bit    = (filt == SYM_ONE) || (filt == SYM_ZERO);
        parity_ok = ^{data, par_bit};
        frame_hit = 1'b0;
        word_done = 1'b0;
        case (state)
            IDLE:  frame_hit = sym_evt && (filt == SYM_STOP);
            DATA:  frame_hit = sym_evt && (filt != SYM_SEP);
            GAP:   frame_hit = sym_evt && (filt == SYM_STOP);
            PAR:   frame_hit = sym_evt && (filt != SYM_SEP);
            PGAP:  frame_hit = sym_evt && is_bit;
            STOPW: begin
                frame_hit = sym_evt && (filt != SYM_SEP);
                word_done = sym_evt && (filt == SYM_SEP);
            end
            default: frame_hit = 1'b0;
        endcase
        // A stalled line inside a word is a framing fault
        if (state != IDLE && state != ERR && !sym_evt && timer == tmo_lim - 10'd1)
            frame_hit = 1'b1;
    end

    // Word assembly FSM, configuration register and sticky host-visible status
    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= IDLE;
            cfg                <= 10'b0100001000;
            data               <= 32'd0;
            bit_cnt            <= 6'd0;
            par_bit            <= 1'b0;
            timer              <= 10'd0;
            bus.rx_data        <= 32'd0;
            bus.word_ready     <= 1'b0;
            bus.parity_err     <= 1'b0;
            bus.frame_err      <= 1'b0;
            bus.overrun        <= 1'b0;
            bus.status_changed <= 1'b0;
        end else begin
            bus.status_changed <= 1'b0;
            if (bus.read_ack) begin
                bus.word_ready <= 1'b0;
                bus.parity_err <= 1'b0;
                bus.frame_err  <= 1'b0;
                bus.overrun    <= 1'b0;
            end
            if (bus.wr_config_enable && state == IDLE && filt == SYM_SEP)
                cfg <= bus.wr_config_w;

            // In ERR the timer measures continuous SEP; elsewhere time since the last change
            if (state == IDLE)
                timer <= 10'd0;
            else if (state == ERR)
                timer <= (filt == SYM_SEP) ? timer + 10'd1 : 10'd0;
            else
                timer <= sym_evt ? 10'd0 : timer + 10'd1;

            if (frame_hit) begin
                state              <= ERR;
                timer              <= 10'd0;
                bus.frame_err      <= 1'b1;
                bus.status_changed <= irqm & ~bus.frame_err;
            end else if (state == ERR) begin
                if (filt == SYM_SEP && timer == tmo_lim - 10'd1)
                    state <= IDLE;
            end else if (sym_evt) begin
                case (state)
                    IDLE: if (is_bit) begin
                        data    <= {31'd0, filt[1]};
                        bit_cnt <= 6'd1;
                        state   <= DATA;
                    end
                    DATA: state <= GAP;
                    GAP: if (is_bit) begin
                        if (bit_cnt < bq_eff) begin
                            data[bit_cnt[4:0]] <= filt[1];
                            bit_cnt            <= bit_cnt + 6'd1;
                            state              <= DATA;
                        end else begin
                            par_bit <= filt[1];
                            state   <= PAR;
                        end
                    end
                    PAR:     state <= PGAP;
                    PGAP:    state <= STOPW;
                    STOPW:   state <= IDLE;
                    default: state <= IDLE;
                endcase
            end

            if (word_done) begin
                if (!bus.word_ready || bus.read_ack) begin
                    bus.rx_data        <= data;
                    bus.word_ready     <= 1'b1;
                    bus.parity_err     <= ~parity_ok;
                    bus.status_changed <= 1'b1;
                end else begin
                    bus.overrun        <= 1'b1;
                    bus.status_changed <= irqm & ~bus.overrun;
                end
            end
        end
    end
endmodule

// File: tb/tb_sl_receiver.sv
// tb/tb_sl_receiver.sv - directed self-checking bench for sl_receiver
module tb_sl_receiver;
    logic clk = 1'b0;
    logic rst;
    logic SL0, SL1;
    int   vec    = 0;
    int   errs   = 0;
    int   sc_cnt = 0;

    sl_receiver_if bus();

    sl_receiver #(.SYNC_STAGES(2), .TIMEOUT_MULT(4)) dut (
        .clk(clk), .rst(rst), .SL0(SL0), .SL1(SL1), .bus(bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (bus.status_changed === 1'b1) sc_cnt++;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_sym(input logic [1:0] s, input int n);
        SL0 = s[1];
        SL1 = s[0];
        tick(n);
    endtask

    function automatic logic odd_par(input logic [31:0] d, input int nb);
        logic x = 1'b0;
        for (int i = 0; i < nb; i++) x ^= d[i];
        return ~x;
    endfunction

    task automatic send_word(input logic [31:0] d, input int nb, input logic par, input int p);
        for (int i = 0; i < nb; i++) begin
            send_sym({d[i], ~d[i]}, p);
            send_sym(2'b11, p);
        end
        send_sym({par, ~par}, p);
        send_sym(2'b11, p);
        send_sym(2'b00, p);
        send_sym(2'b11, p);
        tick(p + 6);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        SL0 = 1'b1;
        SL1 = 1'b1;
        bus.wr_config_w      = 10'd0;
        bus.wr_config_enable = 1'b0;
        bus.read_ack         = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(1);
        sc_cnt = 0;
    endtask

    task automatic pulse_ack();
        bus.read_ack = 1'b1;
        tick(1);
        bus.read_ack = 1'b0;
        tick(1);
    endtask

    task automatic write_cfg(input logic [9:0] v);
        bus.wr_config_w      = v;
        bus.wr_config_enable = 1'b1;
        tick(1);
        bus.wr_config_enable = 1'b0;
        tick(1);
    endtask

    task automatic test_reset();
        do_reset();
        send_sym(2'b10, 8);
        send_sym(2'b11, 8);
        send_sym(2'b01, 8);
        do_reset();
        vec++; if (bus.rx_data !== 32'd0) begin errs++; $display("FAIL reset_rx_data got %h want 0", bus.rx_data); end
        vec++; if ({bus.word_ready, bus.parity_err, bus.frame_err, bus.overrun} !== 4'b0)
            begin errs++; $display("FAIL reset_flags got %b want 0000", {bus.word_ready, bus.parity_err, bus.frame_err, bus.overrun}); end
        vec++; if ({bus.rx_busy, bus.status_changed} !== 2'b00)
            begin errs++; $display("FAIL reset_busy_sc got %b want 00", {bus.rx_busy, bus.status_changed}); end
        vec++; if (bus.r_config_w !== 10'b0100001000) begin errs++; $display("FAIL reset_config got %h want 108", bus.r_config_w); end
    endtask

    task automatic test_basic();
        do_reset();
        send_word(32'hA5, 8, odd_par(32'hA5, 8), 8);
        vec++; if (bus.rx_data !== 32'h000000A5) begin errs++; $display("FAIL basic_data got %h want 000000a5", bus.rx_data); end
        vec++; if ({bus.word_ready, bus.parity_err, bus.frame_err, bus.overrun} !== 4'b1000)
            begin errs++; $display("FAIL basic_flags got %b want 1000", {bus.word_ready, bus.parity_err, bus.frame_err, bus.overrun}); end
        vec++; if (sc_cnt !== 1) begin errs++; $display("FAIL basic_sc_pulses got %0d want 1", sc_cnt); end
        vec++; if (bus.rx_busy !== 1'b0) begin errs++; $display("FAIL basic_busy got %b want 0", bus.rx_busy); end
    endtask

    task automatic test_parity();
        do_reset();
        send_word(32'hA5, 8, ~odd_par(32'hA5, 8), 8);
        vec++; if (bus.rx_data !== 32'h000000A5) begin errs++; $display("FAIL par_data got %h want 000000a5", bus.rx_data); end
        vec++; if ({bus.word_ready, bus.parity_err} !== 2'b11) begin errs++; $display("FAIL par_flags got %b want 11", {bus.word_ready, bus.parity_err}); end
        pulse_ack();
        vec++; if ({bus.word_ready, bus.parity_err} !== 2'b00) begin errs++; $display("FAIL par_ack got %b want 00", {bus.word_ready, bus.parity_err}); end
    endtask

    task automatic test_glitch();
        logic bad = 1'b0;
        do_reset();
        send_sym(2'b01, 3);
        SL0 = 1'b1;
        SL1 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (bus.rx_busy !== 1'b0) bad = 1'b1;
        end
        vec++; if (bad !== 1'b0) begin errs++; $display("FAIL glitch_busy got 1 want 0"); end
        vec++; if ({bus.word_ready, bus.frame_err} !== 2'b00) begin errs++; $display("FAIL glitch_flags got %b want 00", {bus.word_ready, bus.frame_err}); end
        vec++; if (sc_cnt !== 0) begin errs++; $display("FAIL glitch_sc got %0d want 0", sc_cnt); end
    endtask

    task automatic test_overrun();
        do_reset();
        write_cfg(10'h148);
        vec++; if (bus.r_config_w !== 10'h148) begin errs++; $display("FAIL ovr_cfg got %h want 148", bus.r_config_w); end
        send_word(32'h11, 8, odd_par(32'h11, 8), 8);
        send_word(32'h22, 8, odd_par(32'h22, 8), 8);
        vec++; if (bus.rx_data !== 32'h00000011) begin errs++; $display("FAIL ovr_data got %h want 00000011", bus.rx_data); end
        vec++; if ({bus.word_ready, bus.overrun, bus.parity_err} !== 3'b110)
            begin errs++; $display("FAIL ovr_flags got %b want 110", {bus.word_ready, bus.overrun, bus.parity_err}); end
        vec++; if (sc_cnt !== 2) begin errs++; $display("FAIL ovr_sc got %0d want 2", sc_cnt); end
    endtask

    task automatic test_frame();
        do_reset();
        send_word(32'h0AB, 9, 1'b1, 8);
        vec++; if ({bus.frame_err, bus.rx_busy, bus.word_ready} !== 3'b110)
            begin errs++; $display("FAIL frame_err got %b want 110", {bus.frame_err, bus.rx_busy, bus.word_ready}); end
        vec++; if (sc_cnt !== 0) begin errs++; $display("FAIL frame_sc got %0d want 0", sc_cnt); end
        tick(200);
        vec++; if (bus.rx_busy !== 1'b0) begin errs++; $display("FAIL frame_recover got %b want 0", bus.rx_busy); end
        pulse_ack();
        send_word(32'h3C, 8, odd_par(32'h3C, 8), 8);
        vec++; if (bus.rx_data !== 32'h0000003C) begin errs++; $display("FAIL frame_next_data got %h want 0000003c", bus.rx_data); end
        vec++; if ({bus.word_ready, bus.parity_err, bus.frame_err} !== 3'b100)
            begin errs++; $display("FAIL frame_next_flags got %b want 100", {bus.word_ready, bus.parity_err, bus.frame_err}); end
    endtask

    task automatic test_config();
        do_reset();
        fork
            send_word(32'h5A, 8, odd_par(32'h5A, 8), 8);
            begin
                tick(40);
                vec++; if (bus.rx_busy !== 1'b1) begin errs++; $display("FAIL cfg_busy got %b want 1", bus.rx_busy); end
                write_cfg(10'h020);
            end
        join
        vec++; if (bus.r_config_w !== 10'h108) begin errs++; $display("FAIL cfg_ignored got %h want 108", bus.r_config_w); end
        vec++; if (bus.rx_data !== 32'h0000005A) begin errs++; $display("FAIL cfg_word got %h want 0000005a", bus.rx_data); end
        pulse_ack();
        write_cfg(10'h020);
        vec++; if (bus.r_config_w !== 10'h020) begin errs++; $display("FAIL cfg_write got %h want 020", bus.r_config_w); end
        send_word(32'hDEADBEEF, 32, odd_par(32'hDEADBEEF, 32), 2);
        vec++; if (bus.rx_data !== 32'hDEADBEEF) begin errs++; $display("FAIL cfg32_data got %h want deadbeef", bus.rx_data); end
        vec++; if ({bus.word_ready, bus.parity_err, bus.frame_err, bus.overrun} !== 4'b1000)
            begin errs++; $display("FAIL cfg32_flags got %b want 1000", {bus.word_ready, bus.parity_err, bus.frame_err, bus.overrun}); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_glitch();
        test_overrun();
        test_frame();
        test_config();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
